sdram_auto_refresh: RTL

//  Periodic auto-refresh generator for the SDRAM controller. Times the refresh interval once init
//  is done, raises a refresh request to the arbiter, and on the arbiter's start runs PRECHARGE-ALL

---
 rtl/sdram_pkg.sv | 39 +++
 rtl/sdram_auto_refresh.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, idle bus values, timing defaults
// and the one-hot state type used by the refresh sequencer.
package sdram_pkg;

  // Commands as {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP          = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE       = 4'b0011;
  localparam logic [3:0] CMD_READ         = 4'b0101;
  localparam logic [3:0] CMD_WRITE        = 4'b0100;
  localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;

  // Bus values driven while a block has nothing to say
  localparam logic [1:0]  IDLE_BA   = 2'b11;
  localparam logic [12:0] IDLE_ADDR = 13'h1fff;
  // A10 high selects all banks for PRECHARGE
  localparam logic [12:0] PALL_ADDR = 13'h0400;

  // Timing defaults in clock cycles at 100 MHz
  localparam int TRP_DEFAULT  = 2;
  localparam int TRFC_DEFAULT = 7;
  localparam int TRCD_DEFAULT = 2;

  // Refresh sequencer states, one-hot
  typedef enum logic [5:0] {
    AR_IDLE = 6'b000001,
    AR_PCHG = 6'b000010,
    AR_TRP  = 6'b000100,
    AR_AREF = 6'b001000,
    AR_TRFC = 6'b010000,
    AR_END  = 6'b100000
  } aref_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sdram_auto_refresh.sv
// Periodic auto-refresh generator. Times the refresh interval after init,
// requests the bus from the arbiter and, once granted, issues PRECHARGE-ALL
// followed by AREF_NUM AUTO REFRESH commands with tRP/tRFC spacing.
module sdram_auto_refresh
  import sdram_pkg::*;
#(
  parameter int CNT_REF_MAX = 750,
  parameter int TRP_CLK     = TRP_DEFAULT,
  parameter int TRFC_CLK    = TRFC_DEFAULT,
  parameter int AREF_NUM    = 2
) (
  input  logic        i_sysclk,
  input  logic        i_sysrst_n,
  input  logic        i_init_done,
  input  logic        i_refresh_start,
  output logic        o_refresh_request,
  output logic [3:0]  o_refresh_cmd,
  output logic [1:0]  o_refresh_ba,
  output logic [12:0] o_refresh_addr,
  output logic        o_refresh_done
);

  localparam int RW = $clog2(CNT_REF_MAX);
  localparam int CW = $clog2(max_int(TRP_CLK, TRFC_CLK) + 1);
  localparam int AW = $clog2(AREF_NUM + 1);

  localparam logic [RW-1:0] REF_LAST   = RW'(CNT_REF_MAX - 1);
  localparam logic [CW-1:0] TRP_LAST   = CW'(TRP_CLK - 1);
  localparam logic [CW-1:0] TRFC_LAST  = CW'(TRFC_CLK - 1);
  localparam logic [AW-1:0] AREF_TOTAL = AW'(AREF_NUM);

  // Interval timing and grant detection
  logic [RW-1:0] r_cnt_ref;
  logic          r_refresh_request;
  logic          r_start_d;
  logic          w_ref_term;
  logic          w_start_rise;

  // Sequencer
  aref_state_t   r_state;
  aref_state_t   w_state_next;
  logic [CW-1:0] r_clk_cnt;
  logic [AW-1:0] r_aref_cnt;
  logic [AW-1:0] w_aref_cnt_next;
  logic [3:0]    r_cmd;
  logic [3:0]    w_cmd_next;
  logic [1:0]    r_ba;
  logic [1:0]    w_ba_next;
  logic [12:0]   r_addr;
  logic [12:0]   w_addr_next;
  logic          r_done;
  logic          w_done_next;

  assign w_ref_term   = (r_cnt_ref == REF_LAST);
  // Only an edge of the grant starts a sequence, so a grant level that
  // outlives o_refresh_done cannot retrigger.
  assign w_start_rise = i_refresh_start & ~r_start_d;

  // Interval counter, refresh request and grant edge register
  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      r_cnt_ref         <= '0;
      r_refresh_request <= 1'b0;
      r_start_d         <= 1'b0;
    end else begin
      r_start_d <= i_refresh_start;
      if (!i_init_done) begin
        r_cnt_ref         <= '0;
        r_refresh_request <= 1'b0;
      end else if (w_ref_term) begin
        // A new interval expiring wins over a grant arriving in the same cycle
        r_cnt_ref         <= '0;
        r_refresh_request <= 1'b1;
      end else begin
        r_cnt_ref <= r_cnt_ref + 1'b1;
        if (w_start_rise) begin
          r_refresh_request <= 1'b0;
        end
      end
    end
  end

  // Next-state and next-output decode; outputs follow the state being entered
  always_comb begin
    w_state_next    = r_state;
    w_aref_cnt_next = r_aref_cnt;
    w_cmd_next      = CMD_NOP;
    w_ba_next       = IDLE_BA;
    w_addr_next     = IDLE_ADDR;
    w_done_next     = 1'b0;

    case (r_state)
      AR_IDLE: begin
        if (w_start_rise) begin
          w_state_next = AR_PCHG;
        end
      end
      AR_PCHG: begin
        w_state_next = AR_TRP;
      end
      AR_TRP: begin
        if (r_clk_cnt == TRP_LAST) begin
          w_state_next = AR_AREF;
        end
      end
      AR_AREF: begin
        w_state_next    = AR_TRFC;
        w_aref_cnt_next = r_aref_cnt + 1'b1;
      end
      AR_TRFC: begin
        if (r_clk_cnt == TRFC_LAST) begin
          w_state_next = (r_aref_cnt < AREF_TOTAL) ? AR_AREF : AR_END;
        end
      end
      AR_END: begin
        w_state_next    = AR_IDLE;
        w_aref_cnt_next = '0;
      end
      default: begin
        w_state_next    = AR_IDLE;
        w_aref_cnt_next = '0;
      end
    endcase

    case (w_state_next)
      AR_PCHG: begin
        w_cmd_next  = CMD_PRECHARGE;
        w_addr_next = PALL_ADDR;
      end
      AR_AREF: begin
        w_cmd_next = CMD_AUTO_REFRESH;
      end
      AR_END: begin
        w_done_next = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Sequencer state, shared wait counter and registered command outputs
  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      r_state    <= AR_IDLE;
      r_clk_cnt  <= '0;
      r_aref_cnt <= '0;
      r_cmd      <= CMD_NOP;
      r_ba       <= IDLE_BA;
      r_addr     <= IDLE_ADDR;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_aref_cnt <= w_aref_cnt_next;
      r_cmd      <= w_cmd_next;
      r_ba       <= w_ba_next;
      r_addr     <= w_addr_next;
      r_done     <= w_done_next;
      // The wait counter restarts on every state change and rests in IDLE
      if ((w_state_next != r_state) || (r_state == AR_IDLE)) begin
        r_clk_cnt <= '0;
      end else begin
        r_clk_cnt <= r_clk_cnt + 1'b1;
      end
    end
  end

  assign o_refresh_request = r_refresh_request;
  assign o_refresh_cmd     = r_cmd;
  assign o_refresh_ba      = r_ba;
  assign o_refresh_addr    = r_addr;
  assign o_refresh_done    = r_done;

endmodule
